// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: maps byte-addressed loads/stores onto a word-wide
// single-ported memory, splitting misaligned halfword/word accesses into two words.
module dmem_access_ctrl #(
  parameter int TIMEOUT  = 16,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [2:0]  cpu_memread,
  input  logic [1:0]  cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // S_IDLE: ready | S_FIRST: low/only word | S_SECOND: high word | S_RESP: done pulse
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_RESP} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q;
  logic [1:0]    size_q, k_q;
  logic          sext_q, load_q, split_q;
  logic [31:0]   lo_q;
  logic [3:0]    wstrb_hi_q;
  logic [31:0]   wdata_hi_q;
  logic [TW-1:0] tcnt_q;
  logic          cpu_done_q, cpu_err_q, mem_req_q, mem_we_q;
  logic [31:0]   cpu_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]    mem_wstrb_q;

  logic        in_load, in_store, in_split;
  logic [1:0]  in_size, in_k;
  logic [3:0]  in_mask;
  logic [7:0]  in_strb8;
  logic [63:0] in_wd64;
  logic        ack_last, tmo;
  logic [31:0] rdata_fin;

  function automatic logic [31:0] merge(input logic [31:0] hi, input logic [31:0] lo,
                                        input logic [1:0] k, input logic [1:0] size,
                                        input logic sext);
    logic [63:0] d64;
    logic [31:0] d;
    d64 = {hi, lo} >> {k, 3'b000};
    d   = d64[31:0];
    case (size)
      2'b01:   merge = {{24{sext & d[7]}}, d[7:0]};
      2'b10:   merge = {{16{sext & d[15]}}, d[15:0]};
      2'b11:   merge = d;
      default: merge = 32'h0;
    endcase
  endfunction

  always_comb begin
    in_load  = (cpu_memread[1:0] != 2'b00) && (cpu_memread != 3'b111);
    in_store = !in_load && (cpu_memwrite != 2'b00);
    in_size  = in_load ? cpu_memread[1:0] : cpu_memwrite;
    in_k     = cpu_addr[1:0];
    in_split = ((in_size == 2'b10) && (in_k == 2'b11)) ||
               ((in_size == 2'b11) && (in_k != 2'b00));
    case (in_size)
      2'b01:   in_mask = 4'b0001;
      2'b10:   in_mask = 4'b0011;
      2'b11:   in_mask = 4'b1111;
      default: in_mask = 4'b0000;
    endcase
    in_strb8 = {4'b0000, in_mask} << in_k;
    in_wd64  = {32'h0, cpu_wdata} << {in_k, 3'b000};
  end

  always_comb begin
    ack_last  = mem_ack && ((state_q == S_SECOND) || !split_q);
    tmo       = !mem_ack && (tcnt_q == TW'(TIMEOUT - 1));
    rdata_fin = (state_q == S_SECOND) ? merge(mem_rdata, lo_q, k_q, size_q, sext_q)
                                      : merge(32'h0, mem_rdata, k_q, size_q, sext_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      size_q      <= 2'b00;
      k_q         <= 2'b00;
      sext_q      <= 1'b0;
      load_q      <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= 32'h0;
      wstrb_hi_q  <= 4'h0;
      wdata_hi_q  <= 32'h0;
      tcnt_q      <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_valid) begin
            size_q     <= in_size;
            k_q        <= in_k;
            sext_q     <= !cpu_memread[2];
            load_q     <= in_load;
            split_q    <= in_split;
            wstrb_hi_q <= in_store ? in_strb8[7:4] : 4'h0;
            wdata_hi_q <= in_store ? in_wd64[63:32] : 32'h0;
            if (in_size == 2'b00 || (in_split && !SPLIT_EN)) begin
              state_q     <= S_RESP;
              cpu_done_q  <= 1'b1;
              cpu_rdata_q <= 32'h0;
              cpu_err_q   <= (in_size != 2'b00);
            end else begin
              state_q     <= S_FIRST;
              tcnt_q      <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= in_store;
              mem_addr_q  <= {cpu_addr[31:2], 2'b00};
              mem_wstrb_q <= in_store ? in_strb8[3:0] : 4'h0;
              mem_wdata_q <= in_store ? in_wd64[31:0] : 32'h0;
            end
          end
        end
        S_FIRST, S_SECOND: begin
          if (ack_last || tmo) begin
            state_q     <= S_RESP;
            cpu_done_q  <= 1'b1;
            cpu_err_q   <= tmo;
            cpu_rdata_q <= (ack_last && load_q) ? rdata_fin : 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'h0;
          end else if (mem_ack) begin
            // first half of a split access; request stays asserted into the second word
            state_q     <= S_SECOND;
            tcnt_q      <= '0;
            lo_q        <= mem_rdata;
            mem_addr_q  <= mem_addr_q + 32'd4;
            mem_wstrb_q <= wstrb_hi_q;
            mem_wdata_q <= wdata_hi_q;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q    <= S_IDLE;
          cpu_done_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready = (state_q == S_IDLE);
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a word memory model that supports
// programmable wait states and a hang mode.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [2:0]  cpu_memread = 3'b000;
  logic [1:0]  cpu_memwrite = 2'b00;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(16), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // memory model and transaction log, all owned by one process
  logic [31:0] mem [0:255];
  logic [31:0] tx_addr  [0:255];
  logic [3:0]  tx_strb  [0:255];
  logic [31:0] tx_wdata [0:255];
  logic        tx_we    [0:255];
  int          ntx = 0;
  int          req_cyc = 0;
  int          done_cnt = 0;
  int          wcnt = 0;
  int          wait_cfg = 0;
  logic        hang = 1'b0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_data = 32'h0;

  assign mem_ack   = mem_req && !hang && (wcnt >= wait_cfg);
  assign mem_rdata = mem_ack ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_req) req_cyc <= req_cyc + 1;
    if (cpu_done) done_cnt <= done_cnt + 1;
    if (mem_req && mem_ack) begin
      tx_addr[ntx[7:0]]  <= mem_addr;
      tx_strb[ntx[7:0]]  <= mem_wstrb;
      tx_wdata[ntx[7:0]] <= mem_wdata;
      tx_we[ntx[7:0]]    <= mem_we;
      ntx <= ntx + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    poke_idx = idx; poke_data = data; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic access(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    @(negedge clk);
    while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_req", 32'(cpu_ready), 32'd1);
    cpu_memread = rd; cpu_memwrite = wr; cpu_addr = addr; cpu_wdata = wd; cpu_valid = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_memread = 3'b000; cpu_memwrite = 2'b00;
    lat = 1;
    while (!cpu_done && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!cpu_done) chk("done_wait_expired", 32'(cpu_done), 32'd1);
    rdata = cpu_rdata;
    err   = cpu_err;
    @(posedge clk); #1;
    chk("done_single_cycle", 32'(cpu_done), 32'd0);
  endtask

  int          lat, base, rbase, dbase;
  logic [31:0] rd;
  logic        er;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_done",  32'(cpu_done),  32'd0);
    chk("rst_req",   32'(mem_req),   32'd0);
    chk("rst_rdata", cpu_rdata,      32'h0);
    chk("rst_addr",  mem_addr,       32'h0);
    @(negedge clk) rstn = 1'b1;

    // aligned lw
    poke(8'd64, 32'h8899AABB);
    base = ntx;
    access(3'b011, 2'b00, 32'h100, 32'h0, lat, rd, er);
    chk("lw_lat", lat, 2);
    chk("lw_rdata", rd, 32'h8899AABB);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_ntx", ntx - base, 1);
    chk("lw_addr", tx_addr[base[7:0]], 32'h100);
    chk("lw_we", 32'(tx_we[base[7:0]]), 32'd0);

    // byte loads at k=3
    poke(8'd64, 32'h80FF1234);
    base = ntx;
    access(3'b001, 2'b00, 32'h103, 32'h0, lat, rd, er);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk("lb_ntx", ntx - base, 1);
    access(3'b101, 2'b00, 32'h103, 32'h0, lat, rd, er);
    chk("lbu_rdata", rd, 32'h00000080);
    chk("lbu_lat", lat, 2);

    // misaligned lw
    poke(8'd64, 32'h44332211);
    poke(8'd65, 32'h88776655);
    base = ntx;
    access(3'b011, 2'b00, 32'h102, 32'h0, lat, rd, er);
    chk("mlw_lat", lat, 3);
    chk("mlw_ntx", ntx - base, 2);
    chk("mlw_addr0", tx_addr[base[7:0]], 32'h100);
    chk("mlw_addr1", tx_addr[8'(base + 1)], 32'h104);
    chk("mlw_rdata", rd, 32'h66554433);

    // misaligned sh across a word boundary, then read it back
    poke(8'd63, 32'h0);
    base = ntx;
    access(3'b000, 2'b10, 32'h0FF, 32'h0000BEEF, lat, rd, er);
    chk("msh_lat", lat, 3);
    chk("msh_ntx", ntx - base, 2);
    chk("msh_addr0", tx_addr[base[7:0]], 32'h0FC);
    chk("msh_we0", 32'(tx_we[base[7:0]]), 32'd1);
    chk("msh_strb0", 32'(tx_strb[base[7:0]]), 32'h8);
    chk("msh_wd0", 32'(tx_wdata[base[7:0]][31:24]), 32'hEF);
    chk("msh_addr1", tx_addr[8'(base + 1)], 32'h100);
    chk("msh_strb1", 32'(tx_strb[8'(base + 1)]), 32'h1);
    chk("msh_wd1", 32'(tx_wdata[8'(base + 1)][7:0]), 32'hBE);
    chk("msh_mem0", mem[63], 32'hEF000000);
    chk("msh_mem1", mem[64], 32'h443322BE);
    access(3'b110, 2'b00, 32'h0FF, 32'h0, lat, rd, er);
    chk("mlhu_rdata", rd, 32'h0000BEEF);
    access(3'b010, 2'b00, 32'h0FF, 32'h0, lat, rd, er);
    chk("mlh_rdata", rd, 32'hFFFFBEEF);

    // wait states
    wait_cfg = 2;
    access(3'b011, 2'b00, 32'h100, 32'h0, lat, rd, er);
    chk("wait2_lat", lat, 4);
    chk("wait2_rdata", rd, 32'h443322BE);
    wait_cfg = 1;
    access(3'b011, 2'b00, 32'h102, 32'h0, lat, rd, er);
    chk("wait1_split_lat", lat, 5);
    chk("wait1_split_rdata", rd, 32'h66554433);
    wait_cfg = 0;

    // no-op request and load priority over store
    base = ntx;
    access(3'b000, 2'b00, 32'h100, 32'h0, lat, rd, er);
    chk("nop_lat", lat, 1);
    chk("nop_ntx", ntx - base, 0);
    chk("nop_rdata", rd, 32'h0);
    chk("nop_err", 32'(er), 32'd0);
    base = ntx;
    access(3'b011, 2'b11, 32'h100, 32'hDEADBEEF, lat, rd, er);
    chk("prio_we", 32'(tx_we[base[7:0]]), 32'd0);
    chk("prio_rdata", rd, 32'h443322BE);
    chk("prio_mem", mem[64], 32'h443322BE);

    // timeout, aligned then split
    hang = 1'b1;
    base = ntx; rbase = req_cyc;
    access(3'b011, 2'b00, 32'h100, 32'h0, lat, rd, er);
    chk("tmo_lat", lat, 17);
    chk("tmo_req_cycles", req_cyc - rbase, 16);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_ntx", ntx - base, 0);
    rbase = req_cyc;
    access(3'b011, 2'b00, 32'h102, 32'h0, lat, rd, er);
    chk("tmo_split_lat", lat, 17);
    chk("tmo_split_req_cycles", req_cyc - rbase, 16);
    chk("tmo_split_err", 32'(er), 32'd1);
    hang = 1'b0;
    access(3'b011, 2'b00, 32'h100, 32'h0, lat, rd, er);
    chk("post_tmo_lat", lat, 2);
    chk("post_tmo_err", 32'(er), 32'd0);
    chk("post_tmo_rdata", rd, 32'h443322BE);

    // reset during the second half of a split lw
    wait_cfg = 3;
    @(negedge clk);
    cpu_memread = 3'b011; cpu_addr = 32'h102; cpu_valid = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_memread = 3'b000;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && mem_addr == 32'h104) break;
      @(posedge clk); #1;
    end
    chk("rstmid_in_second", 32'(mem_req && mem_addr == 32'h104), 32'd1);
    dbase = done_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_req",   32'(mem_req),   32'd0);
    chk("rstmid_addr",  mem_addr,       32'h0);
    chk("rstmid_strb",  32'(mem_wstrb), 32'h0);
    chk("rstmid_done",  32'(cpu_done),  32'd0);
    chk("rstmid_rdata", cpu_rdata,      32'h0);
    chk("rstmid_ready", 32'(cpu_ready), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_cfg = 0;
    repeat (2) @(negedge clk);
    chk("rstmid_no_done", done_cnt - dbase, 0);
    chk("rstmid_ready_after", 32'(cpu_ready), 32'd1);

    base = ntx;
    access(3'b000, 2'b11, 32'h200, 32'h12345678, lat, rd, er);
    chk("sw_lat", lat, 2);
    chk("sw_ntx", ntx - base, 1);
    chk("sw_addr", tx_addr[base[7:0]], 32'h200);
    chk("sw_strb", 32'(tx_strb[base[7:0]]), 32'hF);
    chk("sw_wdata", tx_wdata[base[7:0]], 32'h12345678);
    chk("sw_mem", mem[128], 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every load/store from the MEM stage onto the single-ported, word-addressed data memory.
- Aligned accesses complete in one memory transaction. Misaligned halfword/word accesses are split into two word transactions and merged.
- Load data is returned already shifted to bit 0 and sign- or zero-extended; store data is returned lane-placed with byte strobes.
- Holds the pipeline via cpu_ready until the access is done; times out a hung memory.

Parameters:
- TIMEOUT, 16: max cycles mem_req may wait for mem_ack per transaction before abort (≥2).
- SPLIT_EN, 1: 1 = split misaligned accesses; 0 = misaligned access flags cpu_err with no memory transaction.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- cpu_valid  in  1  request valid
- cpu_ready  out  1  controller idle, request accepted when cpu_valid&cpu_ready
- cpu_memread  in  3  001 lb, 010 lh, 011 lw, 101 lbu, 110 lhu, other = no load
- cpu_memwrite  in  2  01 sb, 10 sh, 11 sw, 00 = no store
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, LSB-justified
- cpu_done  out  1  one-cycle pulse, access finished
- cpu_rdata  out  32  extended load data, valid with cpu_done, held until next done
- cpu_err  out  1  valid with cpu_done: timeout or misaligned with SPLIT_EN=0
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits[1:0]=00
- mem_wstrb  out  4  byte lane enables
- mem_wdata  out  32  lane-placed write data
- mem_rdata  in  32  read word, valid in the mem_ack cycle
- mem_ack  in  1  transaction complete

Behaviour:
- States: IDLE, FIRST, SECOND, RESP. Reset → IDLE.
- Reset values: cpu_done=0, cpu_rdata=0, cpu_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0. cpu_ready = (state==IDLE).
- Reset mid-transaction abandons the transaction immediately; there is no completion pulse.
- Request latching:
  - Accept latches op, addr, wdata. k = addr[1:0].
  - A valid load code has priority; cpu_memwrite is ignored when a load code is valid.
  - Neither a valid load nor a store: go to RESP directly with cpu_rdata=0, err=0, and no mem_req.
- Split condition: halfword with k=3, or word with k≠0. Byte accesses are never split.
- FIRST: mem_addr = {addr[31:2],2'b00}; mem_req=1.
  - On mem_ack, capture lo=mem_rdata.
  - Go to SECOND if split, else RESP.
- SECOND: mem_addr = first address + 4, wrapping modulo 2^32. On mem_ack, capture hi; go to RESP.
- mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are registered. They are stable from assertion until the ack cycle inclusive.
  - Aligned transaction: mem_req drops the cycle after ack.
  - Split transaction: the second transaction's fields load in the cycle after the first ack.
- Load merge:
  - d = ({hi,lo} >> 8k)[31:0], with hi=0 when not split.
  - lb/lbu use d[7:0] with sign/zero extension. lh/lhu use d[15:0] with sign/zero extension. lw uses d.
- Store lanes: mask m = 0001 (sb), 0011 (sh), 1111 (sw).
  - First transaction: wstrb = (m<<k)[3:0], wdata = cpu_wdata<<8k.
  - Second transaction: wstrb = (m<<k)[7:4], wdata = cpu_wdata>>(8·(4−k)).
- Timeout: a counter clears on entering FIRST/SECOND and increments while mem_req&!mem_ack.
  - When it reaches TIMEOUT: drop mem_req, go to RESP with err=1, cpu_rdata=0.
  - A split access whose first half times out does not issue its second half.
- SPLIT_EN=0 with a split condition: RESP with err=1, no mem_req.
- RESP: cpu_done=1 for one cycle, then IDLE.
  - cpu_ready is 0 from the accept edge until RESP exits.
  - A new request can be accepted in the first IDLE cycle after RESP.
- Latency, from the accept edge to cpu_done high, for a zero-wait memory (mem_ack same cycle as mem_req):
  - Aligned access: 2 cycles.
  - Split access: 3 cycles.
  - Each memory wait cycle adds 1.
- mem_ack outside FIRST/SECOND is ignored.

Test Plan:
- Aligned lw: addr 0x100, memory word 0x8899AABB, zero-wait ack → mem_addr 0x100, one mem_req; cpu_done 2 cycles after accept; cpu_rdata 0x8899AABB, err 0.
- lb/lbu: addr 0x103, word 0x80FF1234 → lb returns 0xFFFFFF80, lbu returns 0x00000080; single transaction each.
- Misaligned lw: addr 0x102, words 0x44332211 @0x100 and 0x88776655 @0x104 → transactions to 0x100 then 0x104; cpu_rdata 0x66554433; done 3 cycles after accept.
- Misaligned sh: addr 0x0FF, wdata 0x0000BEEF → first write 0x0FC, wstrb 1000, wdata[31:24]=0xEF; second write 0x100, wstrb 0001, wdata[7:0]=0xBE.
- Timeout: TIMEOUT=16, mem_ack held 0 → mem_req drops after 16 cycles; cpu_done with err 1, cpu_rdata 0; next request is accepted normally.
- Reset: rstn low during SECOND of a split lw → all outputs 0 immediately, no cpu_done; after release cpu_ready=1 and a fresh sw to 0x200 (wdata 0x12345678) writes wstrb 1111.
